// File: rtl/udp_tx_packer.sv
// udp_tx_packer: FIFO-backed payload assembler feeding the UDP transmitter.
// User words are buffered, and a packet is launched either when a full payload
// is available or when a partial payload has sat idle for TIMEOUT_CYC cycles.
module udp_tx_packer #(
  parameter int ADDR_W      = 8,
  parameter int PKT_WORDS   = 64,
  parameter int TIMEOUT_CYC = 2500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [31:0]       wr_data,
  output logic              wr_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow,
  output logic              tx_start_en,
  output logic [15:0]       tx_byte_num,
  output logic [31:0]       tx_data,
  input  logic              tx_req,
  input  logic              tx_done,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   PKT_L   = (ADDR_W+1)'(PKT_WORDS);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [TW-1:0]     T_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0]     T_TRIG  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]     T_ONE   = TW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    SEND      = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   level;
  logic [ADDR_W:0]   remaining;
  logic [TW-1:0]     timer;
  logic              wr_acc, pop, discard, launch;
  logic [ADDR_W:0]   launch_n;
  logic [ADDR_W:0]   level_inc, level_dec;

  // Payload byte count of an n-word packet, kept modulo 2^16.
  function automatic logic [15:0] byte_count(input logic [ADDR_W:0] n);
    logic [15:0] w;
    w = 16'(n);
    return w << 2;
  endfunction

  assign wr_full  = (level == DEPTH_L);
  assign wr_level = level;
  assign busy     = (state != IDLE);

  // Fullness is judged on the registered level, so a read in the same cycle
  // never makes room for a write. An early tx_done overrides any pop.
  assign wr_acc    = wr_en & ~wr_full;
  assign discard   = (state == SEND) & tx_done;
  assign pop       = (state == SEND) & tx_req & (remaining != '0) & ~tx_done;
  assign level_inc = (ADDR_W+1)'(wr_acc);
  assign level_dec = discard ? remaining : (ADDR_W+1)'(pop);

  // Next-state decode, launch decision and start pulse.
  always_comb begin
    state_nxt   = state;
    tx_start_en = 1'b0;
    launch      = 1'b0;
    launch_n    = PKT_L;
    case (state)
      IDLE: begin
        if (level >= PKT_L) begin
          launch   = 1'b1;
          launch_n = PKT_L;
        end else if ((level != '0) && (timer == T_TRIG)) begin
          launch   = 1'b1;
          launch_n = level;
        end
        if (launch) state_nxt = START;
      end
      START: begin
        tx_start_en = 1'b1;
        state_nxt   = SEND;
      end
      SEND: begin
        if (tx_done)
          state_nxt = IDLE;
        else if ((remaining == '0) || (pop && (remaining == ONE_L)))
          state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Packet length snapshot and countdown of words still owed to the transmitter.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining   <= '0;
      tx_byte_num <= '0;
    end else if (launch) begin
      remaining   <= launch_n;
      tx_byte_num <= byte_count(launch_n);
    end else if (discard) begin
      remaining   <= '0;
    end else if (pop) begin
      remaining   <= remaining - ONE_L;
    end
  end

  // Payload storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy; an early tx_done skips the unsent words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (discard)  rd_ptr <= rd_ptr + remaining[ADDR_W-1:0];
      else if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      level <= level + level_inc - level_dec;
    end
  end

  // Read stage: popped word appears on tx_data one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst)      tx_data <= '0;
    else if (pop) tx_data <= mem[rd_ptr];
  end

  // Idle timer: runs only while IDLE with buffered data and no new writes.
  always_ff @(posedge clk) begin
    if (rst)
      timer <= '0;
    else if (wr_acc || (level == '0) || (state != IDLE))
      timer <= '0;
    else if (timer != T_MAX)
      timer <= timer + T_ONE;
  end

  // Sticky overflow flag for writes attempted while full.
  always_ff @(posedge clk) begin
    if (rst)                  overflow <= 1'b0;
    else if (wr_en && wr_full) overflow <= 1'b1;
  end

endmodule

// File: doc/udp_tx_packer.md
Name: udp_tx_packer

Overview:
- Packet-assembly buffer directly upstream of the UDP transmit path, in the Ethernet transmit clock domain.
- Accepts a stream of 32-bit words from user logic and stores them in an internal FIFO.
- Launches a UDP packet when a full payload has accumulated, or when an idle timeout expires with partial data.
- Drives the send handshake (tx_start_en, tx_byte_num, tx_data) and services tx_req / tx_done from the UDP transmitter.

Parameters:
- ADDR_W, 8: FIFO address width; depth = 2^ADDR_W words.
- PKT_WORDS, 64: payload words per full packet. Must satisfy 1 <= PKT_WORDS <= 2^ADDR_W and PKT_WORDS*4 <= 1472.
- TIMEOUT_CYC, 2500: idle cycles with a partial payload before a short packet is flushed. Must be >= 1.

Ports:
- clk  in  1  Ethernet transmit clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for wr_data.
- wr_data  in  32  payload word; first byte sent = wr_data[31:24].
- wr_full  out  1  FIFO full (level == 2^ADDR_W).
- wr_level  out  ADDR_W+1  words currently stored.
- overflow  out  1  sticky; set when wr_en is seen while wr_full; cleared only by rst.
- tx_start_en  out  1  one-cycle pulse that starts a packet.
- tx_byte_num  out  16  payload byte count of the current packet.
- tx_data  out  32  payload word to the transmitter.
- tx_req  in  1  transmitter requests the next word.
- tx_done  in  1  transmitter finished the packet (one-cycle pulse).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: one clock and one synchronous active-high reset (clk, rst); nothing is asynchronous.
  - Outputs: tx_start_en=0, tx_byte_num=0, tx_data=0, busy=0, overflow=0, wr_level=0, wr_full=0.
  - Internal: FIFO pointers=0, timer=0, state=IDLE.
  - Reset mid-packet abandons the packet and empties the FIFO.
- Write:
  - Accepted when wr_en=1 and wr_full=0, judged at the start of the cycle. A same-cycle read does not free space for the write.
  - A rejected write is dropped and sets overflow.
  - Writes are accepted in every state.
- Level: +1 per accepted write, -1 per read; unchanged when both occur in the same cycle. Pointers wrap modulo 2^ADDR_W.
- Timer:
  - Clears on any accepted write, or when level == 0, or when state != IDLE.
  - Otherwise increments, saturating at TIMEOUT_CYC.
- FSM states: IDLE, START, SEND, WAIT_DONE.
- IDLE:
  - If level >= PKT_WORDS: set n = PKT_WORDS and go to START.
  - Else if level > 0 and timer == TIMEOUT_CYC-1: set n = level (snapshot) and go to START.
  - A full packet takes priority over the timeout.
  - On the transition, tx_byte_num <= n*4, truncated to 16 bits; remaining <= n.
- START:
  - tx_start_en = 1 for exactly this cycle; go to SEND.
  - tx_byte_num is held stable from START until the return to IDLE.
- SEND:
  - Each cycle with tx_req=1 and remaining > 0 pops one word; tx_data takes that word on the next rising edge (1-cycle read latency); remaining decrements.
  - When remaining reaches 0, go to WAIT_DONE.
  - tx_req while remaining == 0 is ignored; tx_data holds its last value.
- WAIT_DONE: tx_done=1 returns to IDLE.
- tx_done while still in SEND (short read by the transmitter):
  - Read pointer advances by remaining and level drops by remaining, discarding the unsent words of this packet.
  - Go to IDLE.
- Words written during a packet are never included in that packet. They are eligible for the next packet; the next launch decision is evaluated in the cycle after the return to IDLE.
- tx_start_en is never asserted again before tx_done has been seen for the current packet.

Test Plan:
- Full packet: after rst, write 64 words 0x00000000..0x0000003F with no gaps → one tx_start_en pulse with tx_byte_num=256. Answering tx_req one word per cycle returns those 64 words in order; tx_done → busy=0, wr_level=0.
- Timeout flush: write 5 words then idle → tx_start_en exactly 2500 cycles after the last write, with tx_byte_num=20 and 5 words delivered.
- Overflow: hold tx_req=0 and write 257 words → wr_full=1 at 256, 257th dropped, overflow=1. Then drain 4 packets of 256 bytes; data matches the first 256 words.
- Concurrent write/read: write continuously while a packet is being sent → wr_level stays constant during the overlap. The second packet contains exactly words 64..127.
- Early tx_done: after 10 of 64 words are read, pulse tx_done → state IDLE, wr_level drops by 54, next packet starts with word 64.
- Reset mid-SEND: assert rst for 1 cycle → busy=0, wr_level=0, tx_start_en=0. The next 64 writes produce a correct fresh packet.
